// File: rtl/pulse_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_timer_pkg
//  Description : Shared state encoding for the pulse timer FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package pulse_timer_pkg;

   // Two-state controller: waiting for start, or counting out pulses.
   typedef enum logic [0:0] {
      PT_IDLE = 1'b0,
      PT_RUN  = 1'b1
   } pt_state_t;

endpackage : pulse_timer_pkg
`default_nettype wire

// File: rtl/pulse_timer_reload_down_counter.sv
`default_nettype none
// ============================================================================
//  Module      : reload_down_counter
//  Description : Down-counter that reloads on an explicit load, or when it
//                is enabled while already at zero (the reload replaces the
//                decrement, so the count never wraps below zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module reload_down_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero,
   output logic [WIDTH-1:0] value
);

   logic [WIDTH-1:0] r_value;

   // Load / reload-at-zero takes priority over the decrement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (load || (en && (r_value == '0))) begin
         r_value <= load_val;
      end else if (en) begin
         r_value <= r_value - WIDTH'(1);
      end
   end

   assign zero  = (r_value == '0);
   assign value = r_value;

endmodule : reload_down_counter
`default_nettype wire

// File: rtl/pulse_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_timer
//  Description : Programmable pulse generator. Emits one-cycle strobes every
//                `period` cycles, continuously (burst==0) or for a finite
//                burst, flagging the final pulse with `done`.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_timer
   import pulse_timer_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int BURST_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               stop,
   input  logic [WIDTH-1:0]   period,
   input  logic [BURST_W-1:0] burst,
   output logic               pulse,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [WIDTH-1:0]   remaining
);

   pt_state_t          r_state;
   logic               r_pulse;
   logic               r_busy;
   logic               r_done;
   logic               r_err;
   logic [WIDTH-1:0]   r_period_q;
   logic [BURST_W-1:0] r_burst_q;
   logic [BURST_W-1:0] r_left;

   logic               w_load;
   logic               w_en;
   logic               w_zero;
   logic [WIDTH-1:0]   w_load_val;
   logic [WIDTH-1:0]   w_cnt;

   // A start only loads the counter when it is legal and not overridden by
   // stop; the counter only runs on edges that are not restart/abort edges.
   assign w_load     = start && !stop && (period != '0);
   assign w_en       = (r_state == PT_RUN) && !start && !stop;
   assign w_load_val = w_load ? (period - WIDTH'(1)) : (r_period_q - WIDTH'(1));

   reload_down_counter #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (w_load),
      .load_val (w_load_val),
      .en       (w_en),
      .zero     (w_zero),
      .value    (w_cnt)
   );

   // Controller: stop beats start, start beats the running count; strobes
   // default low so each one lasts exactly one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PT_IDLE;
         r_pulse    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_period_q <= '0;
         r_burst_q  <= '0;
         r_left     <= '0;
      end else begin
         r_pulse <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         if (stop) begin
            r_state <= PT_IDLE;
            r_busy  <= 1'b0;
         end else if (start) begin
            if (period == '0) begin
               r_err   <= 1'b1;
               r_state <= PT_IDLE;
               r_busy  <= 1'b0;
            end else begin
               r_state    <= PT_RUN;
               r_busy     <= 1'b1;
               r_period_q <= period;
               r_burst_q  <= burst;
               r_left     <= burst;
            end
         end else if ((r_state == PT_RUN) && w_zero) begin
            r_pulse <= 1'b1;
            if (r_burst_q != '0) begin
               r_left <= r_left - BURST_W'(1);
               if (r_left == BURST_W'(1)) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= PT_IDLE;
               end
            end
         end
      end
   end

   assign pulse     = r_pulse;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign remaining = (r_state == PT_RUN) ? w_cnt : '0;

endmodule : pulse_timer
`default_nettype wire
